alu_wb_buffer: RTL and testbench

ALU_WB_BUFFER -- requirements
Module: alu_wb_buffer

---
 rtl/alu_wb_buffer.sv | 149 ++++++++++++++
 tb/tb_alu_wb_buffer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_wb_buffer.sv
// alu_wb_buffer: 2-entry in-order FIFO between the ALU result stage and
// register-file writeback.
//
// Optional build macro: ALU_WB_FLAGS_EN adds per-entry out_zero / out_neg
// flags that are computed when the result is captured.
//
// Handshake: a transfer happens on a rising clk edge when valid and ready
// are both 1 on that side. The producer holds its payload until it sees
// ready. in_ready depends only on held state and rst_n, never on out_ready.
// out_* are driven to 0 whenever out_valid is 0, and hold stable while
// out_ready is 0.
module alu_wb_buffer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_result,
  input  logic [4:0]  in_rd,
  input  logic        in_wen,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_wen,
  output logic [1:0]  occupancy
`ifdef ALU_WB_FLAGS_EN
  ,
  output logic        out_zero,
  output logic        out_neg
`endif
);

  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] result_q [2];
  logic [31:0] result_d [2];
  logic [4:0]  rd_q [2];
  logic [4:0]  rd_d [2];
  logic        wen_q [2];
  logic        wen_d [2];
`ifdef ALU_WB_FLAGS_EN
  logic        zero_q [2];
  logic        zero_d [2];
  logic        neg_q [2];
  logic        neg_d [2];
`endif

  logic push;
  logic pop;

  assign in_ready  = rst_n & (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign occupancy = count_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Head presentation; payload is gated to 0 when nothing is held.
  always_comb begin
    out_result = 32'd0;
    out_rd     = 5'd0;
    out_wen    = 1'b0;
`ifdef ALU_WB_FLAGS_EN
    out_zero   = 1'b0;
    out_neg    = 1'b0;
`endif
    if (out_valid) begin
      out_result = result_q[rd_ptr_q];
      out_rd     = rd_q[rd_ptr_q];
      out_wen    = wen_q[rd_ptr_q];
`ifdef ALU_WB_FLAGS_EN
      out_zero   = zero_q[rd_ptr_q];
      out_neg    = neg_q[rd_ptr_q];
`endif
    end
  end

  // Next-state: flush wins over push/pop; otherwise capture and advance pointers.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    result_d = result_q;
    rd_d     = rd_q;
    wen_d    = wen_q;
`ifdef ALU_WB_FLAGS_EN
    zero_d   = zero_q;
    neg_d    = neg_q;
`endif
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        result_d[wr_ptr_q] = in_result;
        rd_d[wr_ptr_q]     = in_rd;
        // Register 0 is hardwired, so its writes are dropped at capture.
        wen_d[wr_ptr_q]    = in_wen & (in_rd != 5'd0);
`ifdef ALU_WB_FLAGS_EN
        zero_d[wr_ptr_q]   = (in_result == 32'd0);
        neg_d[wr_ptr_q]    = in_result[31];
`endif
        wr_ptr_d = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; reset clears pointers, count and storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        result_q[i] <= 32'd0;
        rd_q[i]     <= 5'd0;
        wen_q[i]    <= 1'b0;
`ifdef ALU_WB_FLAGS_EN
        zero_q[i]   <= 1'b0;
        neg_q[i]    <= 1'b0;
`endif
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < 2; i++) begin
        result_q[i] <= result_d[i];
        rd_q[i]     <= rd_d[i];
        wen_q[i]    <= wen_d[i];
`ifdef ALU_WB_FLAGS_EN
        zero_q[i]   <= zero_d[i];
        neg_q[i]    <= neg_d[i];
`endif
      end
    end
  end

endmodule

// File: tb/tb_alu_wb_buffer.sv
// Directed testbench for alu_wb_buffer with hand-computed expectations.
module tb_alu_wb_buffer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic [4:0]  in_rd;
  logic        in_wen;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic [1:0]  occupancy;
`ifdef ALU_WB_FLAGS_EN
  logic        out_zero;
  logic        out_neg;
`endif

  int n_cmp;
  int n_err;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  alu_wb_buffer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_rd      (in_rd),
    .in_wen     (in_wen),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd),
    .out_wen    (out_wen),
    .occupancy  (occupancy)
`ifdef ALU_WB_FLAGS_EN
    ,
    .out_zero   (out_zero),
    .out_neg    (out_neg)
`endif
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checking task
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic drive(input logic v, input logic [31:0] r, input logic [4:0] rd,
                       input logic w, input logic ordy, input logic fl);
    in_valid  = v;
    in_result = r;
    in_rd     = rd;
    in_wen    = w;
    out_ready = ordy;
    flush     = fl;
  endtask

  // Advance one clock and settle #1 past the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    idle();
    #2;
    // Reset state
    chk("rst_in_ready",  {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_occ",       {30'd0, occupancy}, 32'd0);
    chk("rst_result",    out_result, 32'd0);

    // Push offered during reset is not captured
    drive(1'b1, 32'h5, 5'd3, 1'b1, 1'b0, 1'b0);
    step();
    chk("rst_push_occ",   {30'd0, occupancy}, 32'd0);
    chk("rst_push_valid", {31'd0, out_valid}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk("lat_valid",  {31'd0, out_valid}, 32'd1);
    chk("lat_result", out_result, 32'h5);
    chk("lat_rd",     {27'd0, out_rd}, 32'd3);
    chk("lat_wen",    {31'd0, out_wen}, 32'd1);
    chk("lat_occ",    {30'd0, occupancy}, 32'd1);
    drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    step();
    chk("pop1_occ",    {30'd0, occupancy}, 32'd0);
    chk("pop1_result", out_result, 32'd0);
    chk("pop1_rd",     {27'd0, out_rd}, 32'd0);

    // Fill to two, third push ignored, drain in order
    drive(1'b1, 32'h11, 5'd1, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(32'h11);
    step();
    drive(1'b1, 32'h22, 5'd2, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(32'h22);
    step();
    chk("full_occ",      {30'd0, occupancy}, 32'd2);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    chk("full_head",     out_result, 32'h11);
    drive(1'b1, 32'h33, 5'd4, 1'b1, 1'b0, 1'b0);
    step();
    chk("ovf_occ",  {30'd0, occupancy}, 32'd2);
    chk("hold_head", out_result, 32'h11);
    chk("hold_rd",   {27'd0, out_rd}, 32'd1);
    drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      exp_v = exp_q.pop_front();
      chk("drain_valid", {31'd0, out_valid}, 32'd1);
      chk("drain_head",  out_result, exp_v);
      step();
    end
    chk("drain_empty", {31'd0, out_valid}, 32'd0);
    chk("drain_occ",   {30'd0, occupancy}, 32'd0);

    // Simultaneous push and pop at occupancy 1
    drive(1'b1, 32'hAA, 5'd5, 1'b1, 1'b0, 1'b0);
    step();
    chk("pp_head_a", out_result, 32'hAA);
    drive(1'b1, 32'hBB, 5'd6, 1'b1, 1'b1, 1'b0);
    step();
    chk("pp_occ",    {30'd0, occupancy}, 32'd1);
    chk("pp_head_b", out_result, 32'hBB);
    chk("pp_rd_b",   {27'd0, out_rd}, 32'd6);
    drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    step();
    chk("pp_drain_occ", {30'd0, occupancy}, 32'd0);

    // Write to register 0 is suppressed; wen=0 with rd!=0 stays 0
    drive(1'b1, 32'h7, 5'd0, 1'b1, 1'b0, 1'b0);
    step();
    chk("r0_wen",    {31'd0, out_wen}, 32'd0);
    chk("r0_rd",     {27'd0, out_rd}, 32'd0);
    chk("r0_result", out_result, 32'h7);
    drive(1'b1, 32'h9, 5'd7, 1'b0, 1'b1, 1'b0);
    step();
    chk("nowen_wen", {31'd0, out_wen}, 32'd0);
    chk("nowen_rd",  {27'd0, out_rd}, 32'd7);
    drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    step();

    // Flush at full with push and pop requested
    drive(1'b1, 32'h1, 5'd1, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h2, 5'd2, 1'b1, 1'b0, 1'b0);
    step();
    chk("pre_flush_occ", {30'd0, occupancy}, 32'd2);
    drive(1'b1, 32'h3, 5'd3, 1'b1, 1'b1, 1'b1);
    step();
    chk("flush_occ",      {30'd0, occupancy}, 32'd0);
    chk("flush_valid",    {31'd0, out_valid}, 32'd0);
    chk("flush_result",   out_result, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);

    // Mid-operation reset discards entries immediately
    drive(1'b1, 32'h44, 5'd8, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h55, 5'd9, 1'b1, 1'b0, 1'b0);
    step();
    rst_n = 1'b0;
    #1;
    chk("mrst_occ",      {30'd0, occupancy}, 32'd0);
    chk("mrst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("mrst_result",   out_result, 32'd0);
    rst_n = 1'b1;
    drive(1'b1, 32'h66, 5'd10, 1'b1, 1'b0, 1'b0);
    step();
    chk("mrst_push_occ", {30'd0, occupancy}, 32'd1);
    chk("mrst_push_hd",  out_result, 32'h66);
    chk("mrst_push_rd",  {27'd0, out_rd}, 32'd10);
    drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    step();

`ifdef ALU_WB_FLAGS_EN
    // Per-entry flags
    drive(1'b1, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h8000_0000, 5'd2, 1'b1, 1'b0, 1'b0);
    step();
    chk("flag_zero0", {31'd0, out_zero}, 32'd1);
    chk("flag_neg0",  {31'd0, out_neg}, 32'd0);
    drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    step();
    chk("flag_zero1", {31'd0, out_zero}, 32'd0);
    chk("flag_neg1",  {31'd0, out_neg}, 32'd1);
    step();
    chk("flag_gated", {30'd0, out_zero, out_neg}, 32'd0);
`endif

    idle();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
